// File: rtl/fp_ctrl_pkg.sv
// rtl/fp_ctrl_pkg.sv - shared FSM encoding and latency limits for the FP multiplier arbiter
//
// Contents:
//    fsm_state_t  : arbiter controller states IDLE, LOAD, WAIT, DONE
//    MUL_LAT_MIN  : smallest supported multiplier latency in clk cycles
//    MUL_LAT_MAX  : largest supported multiplier latency in clk cycles
//    CNT_W        : width of the WAIT-phase latency counter

package fp_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } fsm_state_t;

   localparam int MUL_LAT_MIN = 1;
   localparam int MUL_LAT_MAX = 15;
   localparam int CNT_W       = $clog2(MUL_LAT_MAX + 1);

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection
//
// Ports:
//    req  [1:0] in  : request from requester 0 (bit 0) and requester 1 (bit 1)
//    prio       in  : requester favoured when both request (0 or 1)
//    gnt  [1:0] out : one-hot grant, all zero when nobody requests

module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[0] && req[1]) begin
         gnt = prio ? 2'b10 : 2'b01;
      end else if (req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// rtl/fp_mul_arbiter.sv - round-robin sharing of one external FP32 multiplier by two requesters
//
// Parameters:
//    MUL_LAT          : cycles from the end of the load cycle until mul_result is valid (1..15)
// Ports:
//    clk, rst         : rising-edge clock, synchronous active-high reset
//    reqN_valid/ready : operand handshake per requester (N = 0, 1); ready only in IDLE
//    reqN_a, reqN_b   : IEEE-754 single operands per requester
//    out_valid/ready  : result handshake
//    out_result       : captured product
//    out_id           : index of the requester that produced out_result
//    mul_load, mul_en : multiplier control (load strobe, pipeline enable)
//    mul_a, mul_b     : operands towards the multiplier
//    mul_result       : product returned by the multiplier

module fp_mul_arbiter
   import fp_ctrl_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_id,
   output logic        mul_load,
   output logic        mul_en,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [31:0] mul_result
);

   // Out-of-range latencies saturate to the supported window.
   localparam int LAT_C = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN :
                          (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;

   // The counter runs 0 .. LAT_C-1 across the WAIT cycles; the last value
   // marks the cycle in which mul_result is valid.
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LAT_C - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   fsm_state_t       state;
   fsm_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      op_a;
   logic [31:0]      op_b;
   logic [31:0]      res_q;
   logic             id_q;
   logic             prio_q;
   logic [1:0]       gnt;
   logic             grant_fire;
   logic             wait_last;

   rr_arb2 u_arb (
      .req  ({req1_valid, req0_valid}),
      .prio (prio_q),
      .gnt  (gnt)
   );

   // A grant only happens from IDLE and never while reset is held.
   assign grant_fire = (state == IDLE) && !rst && (gnt != 2'b00);
   assign wait_last  = (state == WAIT) && (cnt == LAT_LAST);

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      mul_load   = 1'b0;
      mul_en     = 1'b0;
      out_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_fire) begin
               req0_ready = gnt[0];
               req1_ready = gnt[1];
               state_nxt  = LOAD;
            end
         end
         LOAD: begin
            mul_load  = 1'b1;
            mul_en    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            mul_en = 1'b1;
            if (wait_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         res_q  <= '0;
         id_q   <= 1'b0;
         prio_q <= 1'b0;
      end else begin
         state <= state_nxt;

         // Operands and originator are captured only in the grant cycle, so
         // mul_a/mul_b stay put through LOAD, WAIT and DONE.
         if (grant_fire) begin
            op_a   <= gnt[1] ? req1_a : req0_a;
            op_b   <= gnt[1] ? req1_b : req0_b;
            id_q   <= gnt[1];
            // Favour the requester that was not just served.
            prio_q <= gnt[0];
         end

         if (state == LOAD) begin
            cnt <= '0;
         end else if (state == WAIT) begin
            cnt <= cnt + CNT_ONE;
         end

         if (wait_last) begin
            res_q <= mul_result;
         end
      end
   end

   assign mul_a      = op_a;
   assign mul_b      = op_b;
   assign out_result = res_q;
   assign out_id     = id_q;

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 The block SHALL provide parameter MUL_LAT, default 2, the number of clk cycles from the end of the load cycle until mul_result is valid (legal range 1..15).
REQ-002 The block SHALL provide port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL provide port rst, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL provide ports req0_valid/req1_valid, input, 1 each, requester operand pair valid.
REQ-005 The block SHALL provide ports req0_ready/req1_ready, output, 1 each, operands accepted this cycle.
REQ-006 The block SHALL provide ports req0_a, req0_b, req1_a, req1_b, input, 32 each, IEEE-754 single operands.
REQ-007 The block SHALL provide ports out_valid (output, 1), out_ready (input, 1), out_result (output, 32), and out_id (output, 1, index of the originating requester).
REQ-008 The block SHALL provide multiplier-side ports mul_load (output, 1), mul_en (output, 1), mul_a (output, 32), mul_b (output, 32), and mul_result (input, 32).

Function
REQ-009 The block SHALL implement FSM states IDLE, LOAD, WAIT, DONE.
REQ-010 In IDLE, if any reqN_valid is high, the block SHALL assert reqN_ready combinationally for exactly one granted requester, latch its operands and ID, and move to LOAD.
REQ-011 Grant SHALL be round-robin: when both requesters are valid, the requester not granted last wins; a lone valid requester always wins.
REQ-012 In LOAD (one cycle), the block SHALL drive mul_load=1, mul_en=1, and mul_a/mul_b from the latched operands.
REQ-013 In WAIT, the block SHALL drive mul_load=0 and mul_en=1, hold mul_a/mul_b, and count MUL_LAT cycles; on the last count it SHALL capture mul_result into out_result and move to DONE.
REQ-014 In DONE, the block SHALL assert out_valid with stable out_result/out_id until out_ready is high, then return to IDLE.
REQ-015 out_valid and out_ready high in the same cycle SHALL complete the transfer; the next grant is no earlier than the following cycle.
REQ-016 In IDLE and DONE, the block SHALL drive mul_en=0 and mul_load=0.
REQ-017 reqN_ready SHALL be low in every state except IDLE; requests arriving while busy SHALL wait (requester holds valid and data).
REQ-018 Each operation SHALL take exactly 1 (IDLE grant) + 1 (LOAD) + MUL_LAT (WAIT) cycles to out_valid; throughput is at most one result per MUL_LAT+3 cycles.
REQ-019 Operand latches SHALL not change outside the IDLE grant cycle.

Reset
REQ-020 When rst is high at a clock edge, the block SHALL go to IDLE; out_valid, mul_load, and mul_en SHALL be 0; out_result, mul_a, mul_b, and the counter SHALL be 0; the round-robin pointer SHALL favour requester 0; out_id SHALL be 0.
REQ-021 Reset asserted in LOAD, WAIT or DONE SHALL abort the operation with no out_valid pulse, and the pending result SHALL be discarded.
REQ-022 reqN_ready SHALL be 0 while rst is high.

Structure
REQ-023 The FSM state encoding and the MUL_LAT legal range SHALL live in a shared package fp_ctrl_pkg.
REQ-024 Round-robin grant logic SHALL be a sub-module rr_arb2 (inputs: two requests, pointer; outputs: one-hot grant).
REQ-025 The multiplier SHALL stay external; the block SHALL connect to mul32 only through the mul_* ports.

Verification
REQ-026 Single request: req0 A=0x40BF98C8, B=0x42B363A3, and a model returning 0x44064266 -> mul_load high for 1 cycle, out_valid at cycle 3+MUL_LAT, out_result=0x44064266, out_id=0.
REQ-027 Contention: req0 and req1 held valid together from reset -> grants go req0, req1, req0, req1, and out_id alternates 0,1,0,1.
REQ-028 Backpressure: out_ready held low for 5 cycles in DONE -> out_valid and out_result stable, both ready signals low, no mul_load pulse.
REQ-029 Reset mid-WAIT: rst high for 1 cycle during WAIT -> no out_valid, state IDLE, next grant goes to req0 if both valid.
REQ-030 Back-to-back: out_ready tied high with req1 valid only -> results spaced exactly MUL_LAT+3 cycles apart, out_id=1 each time.
REQ-031 MUL_LAT=1 and MUL_LAT=15 builds -> the REQ-018 latency holds for each.
